// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: IF-stage program counter and instruction fetch request controller.
// Holds the PC, issues a level fetch request (ce), and advances when imem_ack is seen
// without a stall. A flush loads new_pc. One branch target is buffered when the
// redirect arrives while the current fetch has not been accepted.
// Optional feature macro: PC_ALIGN_CHECK_EN adds the misalign output. When misalign
// fires, the fetch request is held off until the next flush.
module pc_fetch_ctrl #(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter int                     INC_STEP     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] new_pc,
    input  logic                branch_flag,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                imem_ack,
    output logic [PC_WIDTH-1:0] pc,
    output logic                ce,
    output logic                fetch_fire,
`ifdef PC_ALIGN_CHECK_EN
    output logic                redir_pending,
    output logic                misalign
`else
    output logic                redir_pending
`endif
);

    typedef enum logic [1:0] {
        S_OFF,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(INC_STEP);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INC_STEP - 1);
`endif

    state_t              state;
    logic [PC_WIDTH-1:0] pend_tgt;
    logic [PC_WIDTH-1:0] redir_tgt;
    logic                load_bad;
    logic                flush_bad;

    // A branch in the same cycle is newer than the buffered target, so it wins.
    always_comb begin
        redir_tgt = branch_flag ? branch_target : pend_tgt;
        load_bad  = 1'b0;
        flush_bad = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        load_bad  = |(redir_tgt & ALIGN_MASK);
        flush_bad = |(new_pc & ALIGN_MASK);
`endif
    end

    // The instruction at pc is accepted when the request is up, acked and not stalled.
    always_comb begin
        fetch_fire = ce & imem_ack & ~stall;
    end

    // Fetch FSM, PC register and redirect buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_OFF;
            ce            <= 1'b0;
            pc            <= RESET_VECTOR;
            redir_pending <= 1'b0;
            pend_tgt      <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign      <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
            case (state)
                S_OFF: begin
                    if (!stall) begin
                        state <= S_RUN;
                        ce    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        pc            <= new_pc;
                        redir_pending <= 1'b0;
                        if (flush_bad) begin
                            state <= S_HALT;
                            ce    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                            misalign <= 1'b1;
`endif
                        end
                    end else if (stall) begin
                        if (branch_flag) begin
                            redir_pending <= 1'b1;
                            pend_tgt      <= branch_target;
                        end
                    end else if (imem_ack) begin
                        redir_pending <= 1'b0;
                        if (branch_flag || redir_pending) begin
                            pc <= redir_tgt;
                            if (load_bad) begin
                                state <= S_HALT;
                                ce    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                                misalign <= 1'b1;
`endif
                            end
                        end else begin
                            pc <= pc + INC;
                        end
                    end else if (branch_flag) begin
                        redir_pending <= 1'b1;
                        pend_tgt      <= branch_target;
                    end
                end
                S_HALT: begin
                    // Only a flush restarts fetching after a misaligned load.
                    if (flush) begin
                        pc            <= new_pc;
                        redir_pending <= 1'b0;
                        if (flush_bad) begin
`ifdef PC_ALIGN_CHECK_EN
                            misalign <= 1'b1;
`endif
                        end else begin
                            state <= S_RUN;
                            ce    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_OFF;
                    ce    <= 1'b0;
                end
            endcase
        end
    end

endmodule
